// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg: segment sizing, configuration legality and stage flag type for pipelined_adder_nbit
package pipe_add_pkg;
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_flags_t;
  function automatic int seg_width(input int num_bit, input int num_stages);
    return num_bit / num_stages;
  endfunction
  function automatic bit cfg_legal(input int num_bit, input int num_stages);
    return num_stages >= 1 && num_stages <= num_bit && num_bit % num_stages == 0;
  endfunction
endpackage

// File: rtl/pipelined_adder_nbit_stage.sv
// pipe_add_stage: one SEG-wide ripple segment plus its pipeline register (ovf with PIPE_ADD_OVF_EN)
module pipe_add_stage import pipe_add_pkg::*; #(
  parameter int NUM_BIT = 16,
  parameter int SEG = 4,
  parameter int IDX = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv,
  input  stage_flags_t       f_i,
  input  logic [NUM_BIT-1:0] a_i,
  input  logic [NUM_BIT-1:0] b_i,
  input  logic [NUM_BIT-1:0] s_i,
  output stage_flags_t       f_o,
  output logic [NUM_BIT-1:0] a_o,
  output logic [NUM_BIT-1:0] b_o,
  output logic [NUM_BIT-1:0] s_o
`ifdef PIPE_ADD_OVF_EN
  , output logic             ovf_o
`endif
);
  logic [SEG:0] seg_d;
  logic [NUM_BIT-1:0] s_d;
  stage_flags_t f_q;
  logic [NUM_BIT-1:0] a_q, b_q, s_q;
  // add this segment on the incoming carry and splice it into the finished lower bits
  always_comb begin
    seg_d = {1'b0, a_i[IDX*SEG +: SEG]} + {1'b0, b_i[IDX*SEG +: SEG]} + {{SEG{1'b0}}, f_i.carry};
    s_d = s_i;
    s_d[IDX*SEG +: SEG] = seg_d[SEG-1:0];
  end
  // the whole transaction moves one stage forward whenever the pipe advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else if (adv) begin
      f_q <= {f_i.valid, seg_d[SEG]};
      a_q <= a_i;
      b_q <= b_i;
      s_q <= s_d;
    end
  end
  assign f_o = f_q;
  assign a_o = a_q;
  assign b_o = b_q;
  assign s_o = s_q;
`ifdef PIPE_ADD_OVF_EN
  logic ovf_q;
  // signed overflow is only meaningful once the top segment is added, i.e. in the last stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (adv) ovf_q <= (a_i[NUM_BIT-1] == b_i[NUM_BIT-1]) && (s_d[NUM_BIT-1] != a_i[NUM_BIT-1]);
  end
  assign ovf_o = ovf_q;
`endif
endmodule

// File: rtl/pipelined_adder_nbit.sv
// pipelined_adder_nbit: NUM_STAGES-deep add/subtract with valid/ready backpressure; PIPE_ADD_OVF_EN adds ovf
module pipelined_adder_nbit import pipe_add_pkg::*; #(
  parameter int NUM_BIT = 16,
  parameter int NUM_STAGES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_BIT-1:0] a,
  input  logic [NUM_BIT-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_BIT-1:0] sum,
  output logic               cout
`ifdef PIPE_ADD_OVF_EN
  , output logic             ovf
`endif
);
  localparam int SEG = seg_width(NUM_BIT, NUM_STAGES);
  if (!cfg_legal(NUM_BIT, NUM_STAGES)) begin : g_illegal
    $fatal(1, "pipelined_adder_nbit: NUM_BIT must be a multiple of NUM_STAGES with 1 <= NUM_STAGES <= NUM_BIT");
  end
  stage_flags_t f_w [NUM_STAGES+1];
  logic [NUM_BIT-1:0] a_w [NUM_STAGES+1];
  logic [NUM_BIT-1:0] b_w [NUM_STAGES+1];
  logic [NUM_BIT-1:0] s_w [NUM_STAGES+1];
  logic adv;
  logic unused_tail;
  // the pipe moves as a unit unless a held result is blocking the output
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign f_w[0] = {in_valid && adv, sub || cin};
  assign a_w[0] = a;
  assign b_w[0] = sub ? ~b : b;
  assign s_w[0] = '0;
`ifdef PIPE_ADD_OVF_EN
  logic [NUM_STAGES-1:0] ovf_w;
  logic unused_ovf;
  assign ovf = ovf_w[NUM_STAGES-1];
  assign unused_ovf = ^ovf_w;
`endif
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    pipe_add_stage #(.NUM_BIT(NUM_BIT), .SEG(SEG), .IDX(k)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv),
      .f_i   (f_w[k]),
      .a_i   (a_w[k]),
      .b_i   (b_w[k]),
      .s_i   (s_w[k]),
      .f_o   (f_w[k+1]),
      .a_o   (a_w[k+1]),
      .b_o   (b_w[k+1]),
      .s_o   (s_w[k+1])
`ifdef PIPE_ADD_OVF_EN
      , .ovf_o (ovf_w[k])
`endif
    );
  end
  assign out_valid = f_w[NUM_STAGES].valid;
  assign cout = f_w[NUM_STAGES].carry;
  assign sum = s_w[NUM_STAGES];
  assign unused_tail = ^{a_w[NUM_STAGES], b_w[NUM_STAGES]};
endmodule
